elastic_if_id_reg: RTL and testbench

Parametrised successor to the fixed IF/ID pipeline register. It carries {PC, instruction} from fetch to decode using a valid/ready handshake and a one-entry skid buffer, so decode back-pressure never drops or duplicates a fetched instruction. It also provides a flush input for branch-taken and exception squash. It emits a canonical bubble (NOP, PC 0) whenever no valid entry is present, and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/sat_counter.sv | 22 ++
 rtl/elastic_if_id_reg.sv | 92 +++++++++
 tb/tb_elastic_if_id_reg.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and default constants used by the IF/ID register
// and other pipeline stages.
package pipe_pkg;

    localparam int INST_W_DEF = 32;
    localparam int PC_W_DEF   = 64;

    // Canonical AArch64 NOP, driven whenever a stage holds no valid entry.
    localparam logic [31:0] ARM_NOP = 32'hD503201F;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for stage performance counters: it sticks at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/elastic_if_id_reg.sv
// Elastic IF/ID pipeline register: a valid/ready stage with a one-entry skid buffer,
// a flush squash, a canonical bubble output and a saturating stall counter.
module elastic_if_id_reg
    import pipe_pkg::*;
#(
    parameter int                INST_W   = INST_W_DEF,
    parameter int                PC_W     = PC_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(ARM_NOP),
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [CNT_W-1:0]  stall_cnt
);

    occ_state_t        state;
    logic [PC_W-1:0]   main_pc;
    logic [INST_W-1:0] main_inst;
    logic [PC_W-1:0]   skid_pc;
    logic [INST_W-1:0] skid_inst;
    logic              accept;
    logic              drain;

    // in_ready comes only from registered state, so out_ready never reaches fetch combinationally.
    assign in_ready  = (state != OCC_TWO) && !reset;
    assign out_valid = (state != OCC_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    assign out_pc   = out_valid ? main_pc   : '0;
    assign out_inst = out_valid ? main_inst : NOP_INST;

    // NOTE: only the occupancy state is reset; slot payloads are qualified by state and need no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OCC_EMPTY;
        end else if (flush) begin
            state <= OCC_EMPTY;
        end else begin
            unique case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        state     <= OCC_ONE;
                        main_pc   <= in_pc;
                        main_inst <= in_inst;
                    end
                end
                OCC_ONE: begin
                    if (accept && drain) begin
                        main_pc   <= in_pc;
                        main_inst <= in_inst;
                    end else if (accept) begin
                        state     <= OCC_TWO;
                        skid_pc   <= in_pc;
                        skid_inst <= in_inst;
                    end else if (drain) begin
                        state <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // Skid is always younger than main, so it moves up on drain.
                    if (drain) begin
                        state     <= OCC_ONE;
                        main_pc   <= skid_pc;
                        main_inst <= skid_inst;
                    end
                end
                default: state <= OCC_EMPTY;
            endcase
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .clear(1'b0),
        .inc  (out_valid && !out_ready && !flush),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_elastic_if_id_reg.sv
// Self-checking bench for elastic_if_id_reg: a queue scoreboard follows every
// cycle, while scenario tasks check the specific values each feature must produce.
module tb_elastic_if_id_reg;
    import pipe_pkg::*;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_pc = '0;
    logic [31:0] in_inst = '0;

    logic        in_ready, out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic [15:0] stall_cnt;

    logic        in_ready3, out_valid3;
    logic [63:0] out_pc3;
    logic [31:0] out_inst3;
    logic [2:0]  stall_cnt3;

    ent_t        q[$];
    logic [63:0] delivered[$];
    int          checks = 0;
    int          failures = 0;
    int          exp_stall = 0;
    int          exp_stall3 = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    elastic_if_id_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .stall_cnt(stall_cnt)
    );

    elastic_if_id_reg #(.CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready3), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid3), .out_ready(out_ready), .out_pc(out_pc3), .out_inst(out_inst3),
        .stall_cnt(stall_cnt3)
    );

    // Scoreboard: mid-cycle, compare both DUTs with the queue model, then advance the model.
    always @(negedge clk) begin : monitor
        ent_t        e;
        logic        mv;
        logic        erdy;
        logic [63:0] epc;
        logic [31:0] einst;
        if (mon_en) begin
            mv    = (q.size() != 0);
            erdy  = (q.size() < 2) && !reset;
            epc   = mv ? q[0].pc : 64'h0;
            einst = mv ? q[0].inst : ARM_NOP;
            checks++;
            if (out_valid !== mv || out_valid3 !== mv) begin
                failures++;
                $display("FAIL sb_out_valid got=%b/%b expected=%b t=%0t", out_valid, out_valid3, mv, $time);
            end
            checks++;
            if (in_ready !== erdy || in_ready3 !== erdy) begin
                failures++;
                $display("FAIL sb_in_ready got=%b/%b expected=%b t=%0t", in_ready, in_ready3, erdy, $time);
            end
            checks++;
            if (out_pc !== epc || out_inst !== einst || out_pc3 !== epc || out_inst3 !== einst) begin
                failures++;
                $display("FAIL sb_payload got=%h:%h expected=%h:%h t=%0t", out_pc, out_inst, epc, einst, $time);
            end
            checks++;
            if (stall_cnt !== 16'(exp_stall) || stall_cnt3 !== 3'(exp_stall3)) begin
                failures++;
                $display("FAIL sb_stall got=%0d/%0d expected=%0d/%0d t=%0t", stall_cnt, stall_cnt3, exp_stall, exp_stall3, $time);
            end
            if (reset) begin
                q.delete();
                exp_stall  = 0;
                exp_stall3 = 0;
            end else begin
                if (mv && !out_ready && !flush) begin
                    if (exp_stall < 65535) exp_stall++;
                    if (exp_stall3 < 7) exp_stall3++;
                end
                if (flush) begin
                    q.delete();
                end else begin
                    if (mv && out_ready) begin
                        e = q.pop_front();
                        delivered.push_back(e.pc);
                    end
                    if (in_valid && erdy) begin
                        e.pc   = in_pc;
                        e.inst = in_inst;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                         input logic ordy, input logic fl, input logic rst);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(posedge clk);
        #2;
    endtask

    function automatic int times_delivered(input logic [63:0] pc);
        int n = 0;
        foreach (delivered[i]) if (delivered[i] == pc) n++;
        return n;
    endfunction

    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_valid3 !== 1'b0 || in_ready3 !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs got v=%b r=%b expected v=0 r=0", out_valid, in_ready);
        end
        checks++;
        if (out_pc !== 64'h0 || out_inst !== 32'hD503201F || out_pc3 !== 64'h0 || out_inst3 !== 32'hD503201F) begin
            failures++;
            $display("FAIL reset_bubble got %h:%h expected 0:d503201f", out_pc, out_inst);
        end
        checks++;
        if (stall_cnt !== 16'd0 || stall_cnt3 !== 3'd0) begin
            failures++;
            $display("FAIL reset_stall got=%0d expected=0", stall_cnt);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_ready got=%b expected=1", in_ready);
        end
        drive(0, 64'h0, 32'h0, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'hD503201F) begin
            failures++;
            $display("FAIL idle got v=%b inst=%h expected v=0 inst=d503201f", out_valid, out_inst);
        end
    endtask

    task automatic test_streaming();
        logic [63:0] pcs[3]   = '{64'h0, 64'h4, 64'h8};
        logic [31:0] insts[3] = '{32'h8B020020, 32'hCB020020, 32'hF8400020};
        for (int i = 0; i < 3; i++) begin
            drive(1, pcs[i], insts[i], 1, 0, 0);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_inst !== insts[i]) begin
                failures++;
                $display("FAIL stream_%0d got v=%b %h:%h expected v=1 %h:%h", i, out_valid, out_pc, out_inst, pcs[i], insts[i]);
            end
        end
        drive(0, 64'h0, 32'h0, 1, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || times_delivered(64'h8) != 1) begin
            failures++;
            $display("FAIL stream_end got v=%b n8=%0d expected v=0 n8=1", out_valid, times_delivered(64'h8));
        end
    endtask

    task automatic test_backpressure();
        drive(1, 64'h10, 32'h11110010, 0, 0, 0);
        checks++;
        if (in_ready !== 1'b1 || out_pc !== 64'h10) begin
            failures++;
            $display("FAIL bp_first got r=%b pc=%h expected r=1 pc=10", in_ready, out_pc);
        end
        drive(1, 64'h14, 32'h11110014, 0, 0, 0);
        checks++;
        if (in_ready !== 1'b0 || out_pc !== 64'h10) begin
            failures++;
            $display("FAIL bp_full got r=%b pc=%h expected r=0 pc=10", in_ready, out_pc);
        end
        drive(0, 64'h0, 32'h0, 0, 0, 0);
        checks++;
        if (out_pc !== 64'h10 || out_inst !== 32'h11110010) begin
            failures++;
            $display("FAIL bp_hold got %h:%h expected 10:11110010", out_pc, out_inst);
        end
        drive(0, 64'h0, 32'h0, 1, 0, 0);
        checks++;
        if (out_pc !== 64'h14 || out_inst !== 32'h11110014 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_skid got %h:%h r=%b expected 14:11110014 r=1", out_pc, out_inst, in_ready);
        end
        drive(0, 64'h0, 32'h0, 1, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || times_delivered(64'h10) != 1 || times_delivered(64'h14) != 1) begin
            failures++;
            $display("FAIL bp_drain got v=%b n10=%0d n14=%0d expected v=0 n10=1 n14=1",
                     out_valid, times_delivered(64'h10), times_delivered(64'h14));
        end
    endtask

    task automatic test_flush_two();
        drive(1, 64'h10, 32'h22220010, 0, 0, 0);
        drive(1, 64'h14, 32'h22220014, 0, 0, 0);
        drive(1, 64'h18, 32'h22220018, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'hD503201F || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_two got v=%b inst=%h r=%b expected v=0 inst=d503201f r=1", out_valid, out_inst, in_ready);
        end
        repeat (3) drive(0, 64'h0, 32'h0, 1, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || times_delivered(64'h18) != 0) begin
            failures++;
            $display("FAIL flush_squash got v=%b n18=%0d expected v=0 n18=0", out_valid, times_delivered(64'h18));
        end
    endtask

    task automatic test_stall_counter();
        drive(0, 64'h0, 32'h0, 0, 0, 1);
        drive(1, 64'h30, 32'h33330030, 0, 0, 0);
        repeat (5) drive(0, 64'h0, 32'h0, 0, 0, 0);
        checks++;
        if (stall_cnt !== 16'd5 || stall_cnt3 !== 3'd5) begin
            failures++;
            $display("FAIL stall_5 got=%0d/%0d expected=5/5", stall_cnt, stall_cnt3);
        end
        repeat (5) drive(0, 64'h0, 32'h0, 0, 0, 0);
        checks++;
        if (stall_cnt !== 16'd10 || stall_cnt3 !== 3'd7) begin
            failures++;
            $display("FAIL stall_sat got=%0d/%0d expected=10/7", stall_cnt, stall_cnt3);
        end
        drive(0, 64'h0, 32'h0, 1, 0, 0);
        drive(1, 64'h34, 32'h33330034, 0, 0, 0);
        drive(0, 64'h0, 32'h0, 0, 1, 0);
        checks++;
        if (stall_cnt !== 16'd10 || stall_cnt3 !== 3'd7 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_flush got=%0d/%0d v=%b expected=10/7 v=0", stall_cnt, stall_cnt3, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 64'h20, 32'h44440020, 0, 0, 0);
        drive(0, 64'h0, 32'h0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 64'h0 || stall_cnt !== 16'd0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got v=%b pc=%h cnt=%0d r=%b expected v=0 pc=0 cnt=0 r=0",
                     out_valid, out_pc, stall_cnt, in_ready);
        end
        drive(1, 64'h24, 32'h44440024, 1, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h24) begin
            failures++;
            $display("FAIL reset_first_accept got v=%b pc=%h expected v=1 pc=24", out_valid, out_pc);
        end
        drive(0, 64'h0, 32'h0, 1, 0, 0);
        checks++;
        if (times_delivered(64'h20) != 0 || times_delivered(64'h24) != 1) begin
            failures++;
            $display("FAIL reset_drop got n20=%0d n24=%0d expected n20=0 n24=1",
                     times_delivered(64'h20), times_delivered(64'h24));
        end
        drive(1, 64'h40, 32'h44440040, 0, 0, 0);
        drive(1, 64'h44, 32'h44440044, 0, 1, 1);
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL flush_reset got v=%b cnt=%0d expected v=0 cnt=0", out_valid, stall_cnt);
        end
        drive(0, 64'h0, 32'h0, 1, 0, 0);
    endtask

    task automatic test_random();
        logic [63:0] pc = 64'h1000;
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), pc, $urandom, 1'($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 15) == 0), 0);
            pc = pc + 64'h4;
        end
        repeat (3) drive(0, 64'h0, 32'h0, 1, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            failures++;
            $display("FAIL random_drain got v=%b left=%0d expected v=0 left=0", out_valid, q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_two();
        test_stall_counter();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
